resample_interp: RTL and testbench

- Parametrised successor to the strobe-register I/Q resampler in the symbol-sync path.
- Accepts a continuous I/Q sample stream plus the timing-loop strobe mk and fractional interval mu.
- Produces one interpolated I/Q symbol per strobe: either sample-hold (legacy mode) or linear interpolation.
- Results are buffered in an output FIFO with a valid/ready handshake toward the phase-recovery stage.

---
 rtl/resample_interp.sv | 246 ++++++++++++++++++++++++
 tb/tb_resample_interp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/resample_interp.sv
// resample_interp
// ---------------
// Symbol-rate I/Q resampler for the symbol-sync path. Every accepted timing
// strobe (in_valid && mk) produces one I/Q symbol: either the sample present
// at the strobe (mode 0, legacy sample-hold) or a linear interpolation
// between the previous and the current sample at fractional position mu
// (mode 1). Results pass through a four-stage pipeline and are buffered in a
// show-ahead FIFO that feeds the phase-recovery stage over valid/ready.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   flush         synchronous clear of history, pipeline, FIFO, overflow, sym_cnt
//   in_valid      input sample qualifier
//   in_i, in_q    signed I/Q samples (DW bits)
//   mk            symbol strobe, honoured only together with in_valid
//   mu            unsigned fractional interval, captured with the strobe
//   mode          0 = hold, 1 = linear interpolation, captured with the strobe
//   out_ready     downstream accept
//   out_valid     FIFO holds at least one symbol
//   out_i, out_q  FIFO head symbol (zero while the FIFO is empty)
//   fifo_level    number of symbols held
//   overflow      sticky flag: a symbol was dropped because the FIFO was full
//   sym_cnt       symbols written into the FIFO, wraps silently

module resample_interp #(
    parameter int SYM_WIDTH = 1,
    parameter int INT_WIDTH = 1,
    parameter int DEC_WIDTH = 14,
    parameter int MU_WIDTH  = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16,
    localparam int DW = SYM_WIDTH + INT_WIDTH + DEC_WIDTH,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_i,
    input  logic [DW-1:0]        in_q,
    input  logic                 mk,
    input  logic [MU_WIDTH-1:0]  mu,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_i,
    output logic [DW-1:0]        out_q,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] sym_cnt
);

    localparam int AW = $clog2(DEPTH);
    // Product width: (DW+1)-bit difference times (MU_WIDTH+1)-bit unsigned mu.
    localparam int PW = DW + MU_WIDTH + 2;
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (MU_WIDTH - 1));

    logic                  strobe;

    // Only the newest sample is kept: the interpolation pair is always
    // (sample before the strobe, sample at the strobe), so x_cur is the
    // complete history the datapath needs.
    logic signed [DW-1:0]  x_cur_i, x_cur_q;

    logic                  s1_valid;
    logic signed [DW-1:0]  s1_a_i, s1_a_q, s1_b_i, s1_b_q;
    logic [MU_WIDTH-1:0]   s1_mu;
    logic                  s1_mode;

    logic                  s2_valid;
    logic signed [DW:0]    s2_d_i, s2_d_q;
    logic signed [DW-1:0]  s2_a_i, s2_a_q, s2_b_i, s2_b_q;
    logic [MU_WIDTH-1:0]   s2_mu;
    logic                  s2_mode;

    logic                  s3_valid;
    logic signed [PW-1:0]  s3_p_i, s3_p_q;
    logic signed [DW-1:0]  s3_a_i, s3_a_q, s3_b_i, s3_b_q;
    logic                  s3_mode;

    logic signed [PW-1:0]  mu_ext, d_ext_i, d_ext_q;
    logic signed [PW-1:0]  rnd_i, rnd_q;
    logic signed [DW-1:0]  y_i, y_q;

    logic signed [DW-1:0]  mem_i [DEPTH];
    logic signed [DW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  full, pop, wr_ok;

    assign strobe = in_valid && mk;

    // History and stage 1: capture the interpolation pair and the strobe
    // controls. The pair uses x_cur before this edge's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cur_i  <= '0;
            x_cur_q  <= '0;
            s1_valid <= 1'b0;
            s1_a_i   <= '0;
            s1_a_q   <= '0;
            s1_b_i   <= '0;
            s1_b_q   <= '0;
            s1_mu    <= '0;
            s1_mode  <= 1'b0;
        end else if (flush) begin
            x_cur_i  <= '0;
            x_cur_q  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= strobe;
            if (in_valid) begin
                x_cur_i <= in_i;
                x_cur_q <= in_q;
            end
            if (strobe) begin
                s1_a_i  <= x_cur_i;
                s1_a_q  <= x_cur_q;
                s1_b_i  <= in_i;
                s1_b_q  <= in_q;
                s1_mu   <= mu;
                s1_mode <= mode;
            end
        end
    end

    // Stage 2: difference one bit wider than the samples so full-scale
    // swings cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_d_i   <= '0;
            s2_d_q   <= '0;
            s2_a_i   <= '0;
            s2_a_q   <= '0;
            s2_b_i   <= '0;
            s2_b_q   <= '0;
            s2_mu    <= '0;
            s2_mode  <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_d_i   <= (DW+1)'(s1_b_i) - (DW+1)'(s1_a_i);
            s2_d_q   <= (DW+1)'(s1_b_q) - (DW+1)'(s1_a_q);
            s2_a_i   <= s1_a_i;
            s2_a_q   <= s1_a_q;
            s2_b_i   <= s1_b_i;
            s2_b_q   <= s1_b_q;
            s2_mu    <= s2_mu == s1_mu ? s2_mu : s1_mu;
            s2_mode  <= s1_mode;
        end
    end

    // mu is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        mu_ext  = PW'(s2_mu);
        d_ext_i = PW'(s2_d_i);
        d_ext_q = PW'(s2_d_q);
    end

    // Stage 3: full-precision product d * mu.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_p_i   <= '0;
            s3_p_q   <= '0;
            s3_a_i   <= '0;
            s3_a_q   <= '0;
            s3_b_i   <= '0;
            s3_b_q   <= '0;
            s3_mode  <= 1'b0;
        end else if (flush) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            s3_p_i   <= d_ext_i * mu_ext;
            s3_p_q   <= d_ext_q * mu_ext;
            s3_a_i   <= s2_a_i;
            s3_a_q   <= s2_a_q;
            s3_b_i   <= s2_b_i;
            s3_b_q   <= s2_b_q;
            s3_mode  <= s2_mode;
        end
    end

    // Stage 4 result: round half up by adding half an LSB before the
    // arithmetic shift. The interpolant lies between a and b, so the
    // truncation to DW bits never loses information.
    always_comb begin
        rnd_i = (s3_p_i + HALF) >>> MU_WIDTH;
        rnd_q = (s3_p_q + HALF) >>> MU_WIDTH;
        y_i   = s3_mode ? DW'(rnd_i + PW'(s3_a_i)) : s3_b_i;
        y_q   = s3_mode ? DW'(rnd_q + PW'(s3_a_q)) : s3_b_q;
    end

    // A write into a full FIFO still succeeds when the head is popped on the
    // same edge; the slot being overwritten is the one leaving.
    assign full      = fifo_level == LW'(DEPTH);
    assign out_valid = fifo_level != '0;
    assign pop       = out_valid && out_ready;
    assign wr_ok     = s3_valid && (!full || pop);
    assign out_i     = out_valid ? mem_i[rd_ptr] : '0;
    assign out_q     = out_valid ? mem_q[rd_ptr] : '0;

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_i[wr_ptr] <= y_i;
            mem_q[wr_ptr] <= y_q;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the written-symbol count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            sym_cnt    <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            sym_cnt    <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr  <= wr_ptr + AW'(1);
                sym_cnt <= sym_cnt + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (s3_valid && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_resample_interp.sv
// tb_resample_interp
// ------------------
// Directed bench for resample_interp with default parameters (DW=16,
// MU_WIDTH=8, DEPTH=8, CNT_WIDTH=16). A table of interpolation vectors with
// hand-computed results checks arithmetic and latency; hand-written
// sequences cover per-strobe mode changes, ignored strobes, backpressure,
// write-at-full with a simultaneous pop, flush and asynchronous reset.

module tb_resample_interp;

    localparam int DW    = 16;
    localparam int MW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int LW    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic signed [DW-1:0] in_i, in_q;
    logic                 mk;
    logic [MW-1:0]        mu;
    logic                 mode;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_i, out_q;
    logic [LW-1:0]        fifo_level;
    logic                 overflow;
    logic [CW-1:0]        sym_cnt;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic signed [DW-1:0] ai, bi, aq, bq;
        logic [MW-1:0]        mu;
        logic                 mode;
        logic signed [DW-1:0] ei, eq;
    } vec_t;

    vec_t vecs [7];

    resample_interp #(
        .SYM_WIDTH(1), .INT_WIDTH(1), .DEC_WIDTH(14),
        .MU_WIDTH(MW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .mk(mk), .mu(mu), .mode(mode),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_i(out_i), .out_q(out_q),
        .fifo_level(fifo_level), .overflow(overflow), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    // Present one input cycle, then return the inputs to idle.
    task automatic applyStimulus(input logic iv, input logic strobe,
                                 input int si, input int sq,
                                 input logic [MW-1:0] smu, input logic smode);
        in_valid = iv;
        mk       = strobe;
        in_i     = DW'(si);
        in_q     = DW'(sq);
        mu       = smu;
        mode     = smode;
        step();
        in_valid = 1'b0;
        mk       = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Check the FIFO head, then pop it.
    task automatic popCheck(input string tag, input int ei, input int eq);
        checkOutput({tag, "_valid"}, int'(out_valid), 1);
        checkOutput({tag, "_i"}, int'(out_i), ei);
        checkOutput({tag, "_q"}, int'(out_q), eq);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        // I/Q pairs, mu, mode and hand-derived interpolants.
        vecs[0] = '{ai: 100,    bi: 300,   aq: -100,  bq: -300,   mu: 8'h80, mode: 1'b1, ei: 200,   eq: -200};
        vecs[1] = '{ai: 0,      bi: 1,     aq: 0,     bq: -1,     mu: 8'h80, mode: 1'b1, ei: 1,     eq: 0};
        vecs[2] = '{ai: 500,    bi: -500,  aq: -500,  bq: 500,    mu: 8'h00, mode: 1'b1, ei: 500,   eq: -500};
        vecs[3] = '{ai: 0,      bi: 256,   aq: 0,     bq: -256,   mu: 8'hFF, mode: 1'b1, ei: 255,   eq: -255};
        vecs[4] = '{ai: 7,      bi: 9,     aq: 3,     bq: -4,     mu: 8'h40, mode: 1'b0, ei: 9,     eq: -4};
        vecs[5] = '{ai: 7,      bi: 9,     aq: 0,     bq: -4,     mu: 8'h40, mode: 1'b1, ei: 8,     eq: -1};
        vecs[6] = '{ai: -32768, bi: 32767, aq: 32767, bq: -32768, mu: 8'hFF, mode: 1'b1, ei: 32511, eq: -32512};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mk = 1'b0;
        in_i = '0; in_q = '0; mu = '0; mode = 1'b0; out_ready = 1'b0;
        idle(2);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_i", int'(out_i), 0);
        checkOutput("rst_out_q", int'(out_q), 0);
        checkOutput("rst_level", int'(fifo_level), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_sym_cnt", int'(sym_cnt), 0);
        rst = 1'b0;
        idle(1);

        // Table: result must appear exactly four cycles after the strobe cycle.
        for (int n = 0; n < 7; n++) begin
            applyStimulus(1'b1, 1'b0, int'(vecs[n].ai), int'(vecs[n].aq), 8'h00, 1'b0);
            applyStimulus(1'b1, 1'b1, int'(vecs[n].bi), int'(vecs[n].bq), vecs[n].mu, vecs[n].mode);
            idle(2);
            checkOutput($sformatf("vec%0d_early", n), int'(out_valid), 0);
            idle(1);
            popCheck($sformatf("vec%0d", n), int'(vecs[n].ei), int'(vecs[n].eq));
            checkOutput($sformatf("vec%0d_popped", n), int'(out_valid), 0);
        end
        checkOutput("table_sym_cnt", int'(sym_cnt), 7);

        // Back-to-back strobes with mode toggled per strobe.
        doFlush();
        applyStimulus(1'b1, 1'b0, 10, -10, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 20, -20, 8'h80, 1'b0);
        applyStimulus(1'b1, 1'b1, 30, -30, 8'h80, 1'b1);
        applyStimulus(1'b1, 1'b1, 40, -40, 8'h80, 1'b0);
        idle(4);
        checkOutput("toggle_level", int'(fifo_level), 3);
        checkOutput("toggle_sym_cnt", int'(sym_cnt), 3);
        popCheck("toggle0", 20, -20);
        popCheck("toggle1", 25, -25);
        popCheck("toggle2", 40, -40);

        // mk without in_valid neither strobes nor disturbs the history.
        doFlush();
        applyStimulus(1'b1, 1'b0, 100, -100, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 999, 999, 8'h80, 1'b1);
        idle(5);
        checkOutput("ignored_mk_level", int'(fifo_level), 0);
        applyStimulus(1'b1, 1'b1, 300, -300, 8'h80, 1'b1);
        idle(4);
        checkOutput("ignored_mk_sym_cnt", int'(sym_cnt), 1);
        popCheck("ignored_mk", 200, -200);

        // Backpressure: 10 strobes into an 8-deep FIFO.
        doFlush();
        for (int j = 1; j <= 10; j++)
            applyStimulus(1'b1, 1'b1, j * 100, -j * 100, 8'h00, 1'b0);
        idle(5);
        checkOutput("bp_level", int'(fifo_level), 8);
        checkOutput("bp_overflow", int'(overflow), 1);
        checkOutput("bp_sym_cnt", int'(sym_cnt), 8);
        checkOutput("bp_hold_i", int'(out_i), 100);
        for (int j = 1; j <= 8; j++)
            popCheck($sformatf("bp_drain%0d", j), j * 100, -j * 100);
        checkOutput("bp_empty", int'(out_valid), 0);

        // Flush with two buffered, three in flight and a strobe in the flush cycle.
        applyStimulus(1'b1, 1'b1, 11, -11, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 22, -22, 8'h00, 1'b0);
        idle(4);
        checkOutput("flush_pre_level", int'(fifo_level), 2);
        applyStimulus(1'b1, 1'b1, 33, -33, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 44, -44, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 55, -55, 8'h00, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 1'b1, 66, -66, 8'h00, 1'b0);
        flush = 1'b0;
        checkOutput("flush_out_valid", int'(out_valid), 0);
        checkOutput("flush_level", int'(fifo_level), 0);
        checkOutput("flush_sym_cnt", int'(sym_cnt), 0);
        checkOutput("flush_overflow", int'(overflow), 0);
        idle(6);
        checkOutput("flush_late_level", int'(fifo_level), 0);
        checkOutput("flush_late_sym_cnt", int'(sym_cnt), 0);

        // Full FIFO: a write coinciding with a pop is accepted.
        doFlush();
        for (int j = 1; j <= 8; j++)
            applyStimulus(1'b1, 1'b1, j * 10, -j * 10, 8'h00, 1'b0);
        idle(4);
        checkOutput("full_level", int'(fifo_level), 8);
        checkOutput("full_overflow_pre", int'(overflow), 0);
        applyStimulus(1'b1, 1'b1, 90, -90, 8'h00, 1'b0);
        idle(2);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checkOutput("full_pop_level", int'(fifo_level), 8);
        checkOutput("full_pop_overflow", int'(overflow), 0);
        checkOutput("full_pop_sym_cnt", int'(sym_cnt), 9);
        for (int j = 2; j <= 9; j++)
            popCheck($sformatf("full_drain%0d", j), j * 10, -j * 10);
        checkOutput("full_empty", int'(out_valid), 0);

        // Asynchronous reset in the middle of an overflowing burst.
        doFlush();
        for (int j = 1; j <= 12; j++)
            applyStimulus(1'b1, 1'b1, j, -j, 8'h00, 1'b0);
        checkOutput("arst_pre_overflow", int'(overflow), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", int'(out_valid), 0);
        checkOutput("arst_level", int'(fifo_level), 0);
        checkOutput("arst_sym_cnt", int'(sym_cnt), 0);
        checkOutput("arst_overflow", int'(overflow), 0);
        #1 rst = 1'b0;
        idle(6);
        checkOutput("arst_late_level", int'(fifo_level), 0);
        checkOutput("arst_late_sym_cnt", int'(sym_cnt), 0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
